// File: rtl/id_decode_queue.sv
// id_decode_queue: DEPTH-entry instruction queue between IF and EX with a
// registered decode stage on the queue head and a load-use interlock.
//
// Optional feature macro: ID_BYPASS_EN
//   defined   : an instruction arriving at an empty queue with a free output
//               register and no hazard is decoded straight into the output
//               register (one cycle from push to id_valid).
//   undefined : every instruction passes through the queue (two cycles).
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   flush           synchronous redirect; empties queue and output register
//   if_valid/ready  IF handshake; if_inst/if_pc carry the instruction
//   ex_ld_valid/rd  load currently held in EX (interlock source)
//   id_valid/ready  EX handshake for the decoded bundle
//   id_*            decoded bundle (pc, imm, register indices, control)
//   q_count         queue occupancy
module id_decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [31:0]            if_inst,
  input  logic [PC_W-1:0]        if_pc,
  input  logic                   ex_ld_valid,
  input  logic [4:0]             ex_ld_rd,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [PC_W-1:0]        id_pc,
  output logic [31:0]            id_imm,
  output logic [4:0]             id_rs1_idx,
  output logic [4:0]             id_rs2_idx,
  output logic [4:0]             id_rd_idx,
  output logic [2:0]             id_funct3,
  output logic [1:0]             id_opa_sel,
  output logic [1:0]             id_opb_sel,
  output logic [4:0]             id_alu_func,
  output logic                   id_rd_mem,
  output logic                   id_wr_mem,
  output logic                   id_reg_wr,
  output logic                   id_cond_br,
  output logic                   id_uncond_br,
  output logic                   id_illegal,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] OPA_RS1  = 2'd0;
  localparam logic [1:0] OPA_PC   = 2'd2;
  localparam logic [1:0] OPA_ZERO = 2'd3;
  localparam logic [1:0] OPB_RS2  = 2'd0;
  localparam logic [1:0] OPB_IMM  = 2'd1;

  localparam logic [4:0] ALU_ADD  = 5'h00;
  localparam logic [4:0] ALU_SUB  = 5'h01;
  localparam logic [4:0] ALU_SLT  = 5'h02;
  localparam logic [4:0] ALU_SLTU = 5'h03;
  localparam logic [4:0] ALU_AND  = 5'h04;
  localparam logic [4:0] ALU_OR   = 5'h05;
  localparam logic [4:0] ALU_XOR  = 5'h06;
  localparam logic [4:0] ALU_SLL  = 5'h07;
  localparam logic [4:0] ALU_SRL  = 5'h08;
  localparam logic [4:0] ALU_SRA  = 5'h09;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [1:0]  opa;
    logic [1:0]  opb;
    logic [4:0]  alu;
    logic        rd_mem;
    logic        wr_mem;
    logic        reg_wr;
    logic        cond_br;
    logic        uncond_br;
    logic        illegal;
  } dec_t;

  // ALU function from funct3; alt selects SUB/SRA
  function automatic logic [4:0] alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_sel = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_sel = ALU_SLL;
      3'd2:    alu_sel = ALU_SLT;
      3'd3:    alu_sel = ALU_SLTU;
      3'd4:    alu_sel = ALU_XOR;
      3'd5:    alu_sel = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  // Full instruction decode; illegal encodings keep their fields but lose all side effects
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t       d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7       = inst[31:25];
    f3       = inst[14:12];
    d        = '0;
    d.rs1    = inst[19:15];
    d.rs2    = inst[24:20];
    d.funct3 = f3;
    d.imm    = {{20{inst[31]}}, inst[31:20]};
    d.opa    = OPA_RS1;
    d.opb    = OPB_IMM;
    d.alu    = ALU_ADD;
    case (inst[6:0])
      OP_R: begin
        d.reg_wr  = 1'b1;
        d.opb     = OPB_RS2;
        d.alu     = alu_sel(f3, f7[5]);
        d.illegal = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      OP_IMM: begin
        d.reg_wr = 1'b1;
        d.alu    = alu_sel(f3, (f3 == 3'd5) && f7[5]);
        if (f3 == 3'd1)      d.illegal = (f7 != 7'h00);
        else if (f3 == 3'd5) d.illegal = (f7 != 7'h00) && (f7 != 7'h20);
      end
      OP_LD: begin
        d.reg_wr  = 1'b1;
        d.rd_mem  = 1'b1;
        d.illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OP_ST: begin
        d.wr_mem  = 1'b1;
        d.imm     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        d.illegal = (f3 > 3'd2);
      end
      OP_BR: begin
        d.cond_br = 1'b1;
        d.opa     = OPA_PC;
        d.imm     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        d.illegal = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OP_JAL: begin
        d.uncond_br = 1'b1;
        d.reg_wr    = 1'b1;
        d.opa       = OPA_PC;
        d.imm       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_JALR: begin
        d.uncond_br = 1'b1;
        d.reg_wr    = 1'b1;
        d.illegal   = (f3 != 3'd0);
      end
      OP_LUI: begin
        d.reg_wr = 1'b1;
        d.opa    = OPA_ZERO;
        d.imm    = {inst[31:12], 12'h000};
      end
      OP_AUIPC: begin
        d.reg_wr = 1'b1;
        d.opa    = OPA_PC;
        d.imm    = {inst[31:12], 12'h000};
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.reg_wr    = 1'b0;
      d.rd_mem    = 1'b0;
      d.wr_mem    = 1'b0;
      d.cond_br   = 1'b0;
      d.uncond_br = 1'b0;
    end
    d.rd = d.reg_wr ? inst[11:7] : 5'd0;
    return d;
  endfunction

  // Load-use check: a used, nonzero source matching the EX load or the load in the output reg
  function automatic logic hazard(input logic [31:0] inst, input logic ex_v,
                                  input logic [4:0] ex_rd, input logic out_ld,
                                  input logic [4:0] out_rd);
    logic       u1;
    logic       u2;
    logic [4:0] s1;
    logic [4:0] s2;
    u1 = inst[6:0] inside {OP_R, OP_IMM, OP_LD, OP_ST, OP_BR, OP_JALR};
    u2 = inst[6:0] inside {OP_R, OP_ST, OP_BR};
    s1 = inst[19:15];
    s2 = inst[24:20];
    hazard = (u1 && (s1 != 5'd0) && ((ex_v && (ex_rd == s1)) || (out_ld && (out_rd == s1)))) ||
             (u2 && (s2 != 5'd0) && ((ex_v && (ex_rd == s2)) || (out_ld && (out_rd == s2))));
  endfunction

  logic [31:0]     r_mem_inst [DEPTH];
  logic [PC_W-1:0] r_mem_pc   [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_if_ready;
  logic            r_valid;
  logic [PC_W-1:0] r_pc;
  dec_t            r_dec;

  logic [AW:0]     w_wr_ptr_nxt;
  logic [AW:0]     w_rd_ptr_nxt;
  logic            w_full_nxt;
  logic            w_valid_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  dec_t            w_dec_nxt;
  logic            w_empty;
  logic            w_free;
  logic [31:0]     w_head_inst;
  logic [PC_W-1:0] w_head_pc;
  dec_t            w_head_dec;
  dec_t            w_in_dec;
  logic            w_out_ld;
  logic            w_head_hz;
  logic            w_push;
  logic            w_pop;
  logic            w_byp;
  logic            w_wr_en;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_free      = !r_valid || id_ready;
  assign w_head_inst = r_mem_inst[r_rd_ptr[AW-1:0]];
  assign w_head_pc   = r_mem_pc[r_rd_ptr[AW-1:0]];
  assign w_head_dec  = decode(w_head_inst);
  assign w_in_dec    = decode(if_inst);
  assign w_out_ld    = r_valid && r_dec.rd_mem;
  assign w_head_hz   = hazard(w_head_inst, ex_ld_valid, ex_ld_rd, w_out_ld, r_dec.rd);
  // if_ready comes only from registered occupancy, so a pop at full never admits a push
  assign w_push      = if_valid && r_if_ready && !flush;
  assign w_pop       = !w_empty && w_free && !w_head_hz && !flush;
`ifdef ID_BYPASS_EN
  assign w_byp       = w_empty && w_free && w_push &&
                       !hazard(if_inst, ex_ld_valid, ex_ld_rd, w_out_ld, r_dec.rd);
`else
  assign w_byp       = 1'b0;
`endif
  assign w_wr_en     = w_push && !w_byp;

  // Pointer next state; pointers carry one wrap bit above the index
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr + CW'(w_wr_en);
    w_rd_ptr_nxt = r_rd_ptr + CW'(w_pop);
    if (flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end
    w_full_nxt = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                 (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
  end

  // Output register next state; payload is held whenever nothing new is loaded
  always_comb begin
    w_valid_nxt = r_valid;
    w_pc_nxt    = r_pc;
    w_dec_nxt   = r_dec;
    if (flush) begin
      w_valid_nxt = 1'b0;
    end else if (w_pop) begin
      w_valid_nxt = 1'b1;
      w_pc_nxt    = w_head_pc;
      w_dec_nxt   = w_head_dec;
    end else if (w_byp) begin
      w_valid_nxt = 1'b1;
      w_pc_nxt    = if_pc;
      w_dec_nxt   = w_in_dec;
    end else if (id_ready) begin
      w_valid_nxt = 1'b0;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_inst[r_wr_ptr[AW-1:0]] <= if_inst;
      r_mem_pc[r_wr_ptr[AW-1:0]]   <= if_pc;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_if_ready <= 1'b1;
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_dec      <= '0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_wr_ptr_nxt - w_rd_ptr_nxt;
      r_if_ready <= !w_full_nxt;
      r_valid    <= w_valid_nxt;
      r_pc       <= w_pc_nxt;
      r_dec      <= w_dec_nxt;
    end
  end

  assign if_ready     = r_if_ready;
  assign q_count      = r_count;
  assign id_valid     = r_valid;
  assign id_pc        = r_pc;
  assign id_imm       = r_dec.imm;
  assign id_rs1_idx   = r_dec.rs1;
  assign id_rs2_idx   = r_dec.rs2;
  assign id_rd_idx    = r_dec.rd;
  assign id_funct3    = r_dec.funct3;
  assign id_opa_sel   = r_dec.opa;
  assign id_opb_sel   = r_dec.opb;
  assign id_alu_func  = r_dec.alu;
  assign id_rd_mem    = r_dec.rd_mem;
  assign id_wr_mem    = r_dec.wr_mem;
  assign id_reg_wr    = r_dec.reg_wr;
  assign id_cond_br   = r_dec.cond_br;
  assign id_uncond_br = r_dec.uncond_br;
  assign id_illegal   = r_dec.illegal;

endmodule

// File: tb/tb_id_decode_queue.sv
// Scoreboard bench for id_decode_queue (DEPTH=4, PC_W=32).
module tb_id_decode_queue;

`ifdef ID_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        ex_ld_valid;
  logic [4:0]  ex_ld_rd;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1_idx;
  logic [4:0]  id_rs2_idx;
  logic [4:0]  id_rd_idx;
  logic [2:0]  id_funct3;
  logic [1:0]  id_opa_sel;
  logic [1:0]  id_opb_sel;
  logic [4:0]  id_alu_func;
  logic        id_rd_mem;
  logic        id_wr_mem;
  logic        id_reg_wr;
  logic        id_cond_br;
  logic        id_uncond_br;
  logic        id_illegal;
  logic [2:0]  q_count;

  id_decode_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .ex_ld_valid(ex_ld_valid), .ex_ld_rd(ex_ld_rd),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx), .id_rd_idx(id_rd_idx),
    .id_funct3(id_funct3), .id_opa_sel(id_opa_sel), .id_opb_sel(id_opb_sel),
    .id_alu_func(id_alu_func), .id_rd_mem(id_rd_mem), .id_wr_mem(id_wr_mem),
    .id_reg_wr(id_reg_wr), .id_cond_br(id_cond_br), .id_uncond_br(id_uncond_br),
    .id_illegal(id_illegal), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags: {reg_wr, rd_mem, wr_mem, cond_br, uncond_br, illegal}
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [5:0]  fl;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [5:0] fl);
    exp_t e;
    e.pc = pc; e.imm = imm; e.rd = rd; e.fl = fl;
    return e;
  endfunction

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] e_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] e_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'h03};
  endfunction

  function automatic logic [31:0] e_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    if_valid = 1'b1; if_inst = inst; if_pc = pc; cur_exp = e;
  endtask

  task automatic idle();
    if_valid = 1'b0;
  endtask

  // One clock: sample handshakes before the edge, update the scoreboard after it
  task automatic tick(output logic acc);
    logic iss;
    exp_t got;
    exp_t e;
    #1;
    acc    = if_valid & if_ready;
    iss    = id_valid & id_ready;
    got.pc = id_pc; got.imm = id_imm; got.rd = id_rd_idx;
    got.fl = {id_reg_wr, id_rd_mem, id_wr_mem, id_cond_br, id_uncond_br, id_illegal};
    @(posedge clk);
    if (iss) begin
      check("issue_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("iss_pc",    64'(got.pc),  64'(e.pc));
        check("iss_imm",   64'(got.imm), 64'(e.imm));
        check("iss_rd",    64'(got.rd),  64'(e.rd));
        check("iss_flags", 64'(got.fl),  64'(e.fl));
      end
    end
    if (flush) sb.delete();
    else if (acc) sb.push_back(cur_exp);
    @(negedge clk);
  endtask

  task automatic step();
    logic a;
    tick(a);
  endtask

  // Offer one instruction until accepted, optionally with random backpressure
  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e, input logic rnd);
    logic a;
    int   k;
    a = 1'b0; k = 0;
    drive(inst, pc, e);
    while (!a && k < 30) begin
      if (rnd) id_ready = 1'($urandom_range(0, 1));
      tick(a);
      k++;
    end
    check("send_accepted", 64'(a), 64'd1);
    idle();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    idle();
    id_ready = 1'b1;
    while ((sb.size() != 0 || id_valid) && k < budget) begin
      step();
      k++;
    end
    check("drain_sb", 64'(sb.size()), 64'd0);
    check("drain_valid", 64'(id_valid), 64'd0);
  endtask

  logic [11:0] t1_imm [4];
  logic [31:0] t7_inst [8];
  exp_t        t7_exp [8];

  initial begin
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0;
    ex_ld_valid = 1'b0; ex_ld_rd = '0; id_ready = 1'b0;
    cur_exp = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_if_ready", 64'(if_ready), 64'd1);
    check("rst_q_count",  64'(q_count),  64'd0);
    check("rst_payload", 64'({id_pc, id_imm, id_rd_idx, id_rs1_idx, id_rs2_idx}), 64'd0);
    check("rst_ctrl", 64'({id_funct3, id_opa_sel, id_opb_sel, id_alu_func, id_rd_mem, id_wr_mem,
                          id_reg_wr, id_cond_br, id_uncond_br, id_illegal}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: four back-to-back ADDIs, latency and throughput
    t1_imm[0] = 12'h7FF; t1_imm[1] = 12'h001; t1_imm[2] = 12'hFFF; t1_imm[3] = 12'h123;
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(e_addi(5'(i + 1), 5'd0, t1_imm[i]), 32'h100 + 32'(4 * i),
            mk(32'h100 + 32'(4 * i), sx12(t1_imm[i]), 5'(i + 1), 6'b100000));
      step();
      if (i == 0) check("t1_latency", 64'(id_valid), 64'(BYP));
      else        check("t1_stream",  64'(id_valid), 64'd1);
    end
    drain(20);

    // 2: backpressure fills the queue; a pop at full does not admit a push
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(e_addi(5'(i + 10), 5'd0, 12'(i)), 32'h200 + 32'(4 * i),
            mk(32'h200 + 32'(4 * i), 32'(i), 5'(i + 10), 6'b100000));
      step();
    end
    check("t2_q_count_full", 64'(q_count), 64'd4);
    check("t2_if_ready_full", 64'(if_ready), 64'd0);
    check("t2_out_valid", 64'(id_valid), 64'd1);
    id_ready = 1'b1;
    drive(e_addi(5'd20, 5'd0, 12'h055), 32'h2FC, mk(32'h2FC, 32'h55, 5'd20, 6'b100000));
    step();
    check("t2_no_push_at_full", 64'(q_count), 64'd3);
    drain(20);

    // 3: load-use interlock against the output reg and against EX
    id_ready = 1'b0;
    drive(e_lw(5'd5, 5'd1, 12'h000), 32'h300, mk(32'h300, 32'h0, 5'd5, 6'b110000));
    step();
    drive(e_add(5'd6, 5'd5, 5'd1), 32'h304, mk(32'h304, 32'h1, 5'd6, 6'b100000));
    step();
    idle();
    check("t3_setup_valid", 64'(id_valid), 64'd1);
    check("t3_setup_count", 64'(q_count), 64'd1);
    ex_ld_valid = 1'b1; ex_ld_rd = 5'd5; id_ready = 1'b1;
    step();
    check("t3_stall_outreg", 64'(id_valid), 64'd0);
    step();
    check("t3_stall_ex", 64'(id_valid), 64'd0);
    check("t3_stall_count", 64'(q_count), 64'd1);
    ex_ld_valid = 1'b0;
    step();
    check("t3_issue_after_drop", 64'(id_valid), 64'd1);
    drain(20);

    // 4: x0 never stalls; a store's rs2 does
    id_ready = 1'b0; ex_ld_valid = 1'b1; ex_ld_rd = 5'd0;
    drive(e_add(5'd6, 5'd0, 5'd1), 32'h400, mk(32'h400, 32'h1, 5'd6, 6'b100000));
    step(); idle(); step();
    check("t4_x0_nostall", 64'(id_valid), 64'd1);
    check("t4_x0_count", 64'(q_count), 64'd0);
    id_ready = 1'b1; step(); id_ready = 1'b0;
    ex_ld_rd = 5'd7;
    drive(e_sw(5'd7, 5'd2, 12'h008), 32'h404, mk(32'h404, 32'h8, 5'd0, 6'b001000));
    step(); idle(); step();
    check("t4_sw_stall", 64'(id_valid), 64'd0);
    check("t4_sw_count", 64'(q_count), 64'd1);
    ex_ld_valid = 1'b0;
    step();
    check("t4_sw_release", 64'(id_valid), 64'd1);
    drain(20);

    // 5: flush with a push offered in the same cycle
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(e_addi(5'd11, 5'd0, 12'(i)), 32'h500 + 32'(4 * i),
            mk(32'h500 + 32'(4 * i), 32'(i), 5'd11, 6'b100000));
      step();
    end
    check("t5_q_count_3", 64'(q_count), 64'd3);
    flush = 1'b1;
    drive(e_addi(5'd12, 5'd0, 12'h0AA), 32'h5F0, mk(32'h5F0, 32'hAA, 5'd12, 6'b100000));
    step();
    flush = 1'b0; idle();
    check("t5_flush_count", 64'(q_count), 64'd0);
    check("t5_flush_valid", 64'(id_valid), 64'd0);
    check("t5_flush_if_ready", 64'(if_ready), 64'd1);
    id_ready = 1'b1;
    repeat (3) step();
    check("t5_quiet", 64'(id_valid), 64'd0);

    // 6: illegal word and negative I-immediate
    id_ready = 1'b0;
    drive(32'hFFFF_FFFF, 32'h600, mk(32'h600, 32'hFFFF_FFFF, 5'd0, 6'b000001));
    step(); idle(); step();
    check("t6_ill_valid", 64'(id_valid), 64'd1);
    check("t6_ill_flag", 64'(id_illegal), 64'd1);
    check("t6_ill_reg_wr", 64'(id_reg_wr), 64'd0);
    id_ready = 1'b1; step(); id_ready = 1'b0;
    drive(e_addi(5'd2, 5'd1, 12'h800), 32'h604, mk(32'h604, 32'hFFFF_F800, 5'd2, 6'b100000));
    step(); idle(); step();
    check("t6_imm_neg", 64'(id_imm), 64'hFFFF_F800);
    drain(20);

    // 7: mixed instruction classes under random backpressure
    t7_inst[0] = {20'hABCDE, 5'd3, 7'h37};
    t7_exp[0]  = mk(32'h700, 32'hABCD_E000, 5'd3, 6'b100000);
    t7_inst[1] = e_sw(5'd7, 5'd2, 12'hFFC);
    t7_exp[1]  = mk(32'h704, 32'hFFFF_FFFC, 5'd0, 6'b001000);
    t7_inst[2] = {1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1100, 1'b1, 7'h63};
    t7_exp[2]  = mk(32'h708, 32'hFFFF_FFF8, 5'd0, 6'b000100);
    t7_inst[3] = {1'b0, 10'b0000001000, 1'b0, 8'h00, 5'd1, 7'h6F};
    t7_exp[3]  = mk(32'h70C, 32'h10, 5'd1, 6'b100010);
    t7_inst[4] = {20'h00001, 5'd4, 7'h17};
    t7_exp[4]  = mk(32'h710, 32'h1000, 5'd4, 6'b100000);
    t7_inst[5] = {12'h004, 5'd6, 3'b000, 5'd5, 7'h67};
    t7_exp[5]  = mk(32'h714, 32'h4, 5'd5, 6'b100010);
    t7_inst[6] = e_lw(5'd8, 5'd9, 12'hFFF);
    t7_exp[6]  = mk(32'h718, 32'hFFFF_FFFF, 5'd8, 6'b110000);
    t7_inst[7] = e_add(5'd10, 5'd8, 5'd9);
    t7_exp[7]  = mk(32'h71C, 32'h9, 5'd10, 6'b100000);
    for (int i = 0; i < 8; i++) send(t7_inst[i], t7_exp[i].pc, t7_exp[i], 1'b1);
    drain(40);

    // 8: reset in the middle of traffic leaves nothing behind
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(e_addi(5'd13, 5'd0, 12'(i)), 32'h800 + 32'(4 * i),
            mk(32'h800 + 32'(4 * i), 32'(i), 5'd13, 6'b100000));
      step();
    end
    idle();
    rst = 1'b0;
    #1;
    check("t8_rst_count", 64'(q_count), 64'd0);
    check("t8_rst_valid", 64'(id_valid), 64'd0);
    check("t8_rst_if_ready", 64'(if_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    id_ready = 1'b1;
    send(e_addi(5'd14, 5'd0, 12'h321), 32'h900, mk(32'h900, 32'h321, 5'd14, 6'b100000), 1'b0);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
